// File: rtl/enigma_pkg.sv
// enigma_pkg: shared types, rotor constants and helpers for the enigma controller.
// Contents:
//   LETTERS            alphabet size (26)
//   letter_t           one-hot letter, bit i = letter i ('A' = bit 0)
//   pos_t              rotor position 0..25
//   NOTCH1/2/3         default turnover positions of rotors I, II, III
//   state_t            controller FSM states
//   is_onehot          true when exactly one letter bit is set
//   pos_inc            increment a position modulo 26
//   pos_wrap, pos_bad  fold a raw 5-bit config value into 0..25 / flag it out of range
package enigma_pkg;

  localparam int LETTERS = 26;

  typedef logic [25:0] letter_t;
  typedef logic [4:0]  pos_t;

  localparam pos_t NOTCH1 = 5'd16;  // rotor I  'Q'
  localparam pos_t NOTCH2 = 5'd4;   // rotor II 'E'
  localparam pos_t NOTCH3 = 5'd21;  // rotor III 'V'

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STEP = 2'd1,
    ST_ENC  = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  // Clearing the lowest set bit leaves zero only for a power of two.
  function automatic logic is_onehot(letter_t l);
    return (l != 26'd0) && ((l & (l - 26'd1)) == 26'd0);
  endfunction

  function automatic pos_t pos_inc(pos_t p);
    return (p >= 5'd25) ? 5'd0 : p + 5'd1;
  endfunction

  // Raw values 26..31 fold to 0..5.
  function automatic pos_t pos_wrap(pos_t p);
    return (p > 5'd25) ? p - 5'd26 : p;
  endfunction

  function automatic logic pos_bad(pos_t p);
    return p > 5'd25;
  endfunction

endpackage

// File: rtl/enigma_stepper.sv
// enigma_stepper: combinational next-position logic for a three-rotor stack.
// Optional feature macro: ENIGMA_DOUBLE_STEP_EN (historical double-step of rotor II).
// Ports:
//   n1_i, n2_i, n3_i   current (pre-step) rotor positions, n1 is the fastest rotor
//   n1_o, n2_o, n3_o   positions after one keypress
module enigma_stepper
  import enigma_pkg::*;
#(
  parameter logic [4:0] NOTCH1_P = NOTCH1,
  parameter logic [4:0] NOTCH2_P = NOTCH2
) (
  input  logic [4:0] n1_i,
  input  logic [4:0] n2_i,
  input  logic [4:0] n3_i,
  output logic [4:0] n1_o,
  output logic [4:0] n2_o,
  output logic [4:0] n3_o
);

  logic c1, c2, step2, step3;

  always_comb begin
    // Carries are judged on pre-step positions only.
    c1 = (n1_i == NOTCH1_P);
    c2 = (n2_i == NOTCH2_P);
`ifdef ENIGMA_DOUBLE_STEP_EN
    // Rotor II at its notch is pushed by the rotor III pawl too, so it steps itself.
    step2 = c1 | c2;
    step3 = c2;
`else
    // Odometer: rotor III only moves when rotor II actually leaves its notch.
    step2 = c1;
    step3 = c1 & c2;
`endif
    n1_o = pos_inc(n1_i);
    n2_o = step2 ? pos_inc(n2_i) : n2_i;
    n3_o = step3 ? pos_inc(n3_i) : n3_i;
  end

endmodule

// File: rtl/enigma_controller.sv
// enigma_controller: sequences the combinational enigma core one keypress at a time.
// Accepts a one-hot letter, steps the rotors, samples the core result and
// offers it downstream, all over valid/ready. Macro ENIGMA_DOUBLE_STEP_EN
// selects historical double-stepping (see enigma_stepper).
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   cfg_load_i            load start positions cfg_n1_i..cfg_n3_i (highest priority)
//   in_valid_i/in_ready_o/in_letter_i     keypress handshake and one-hot letter
//   core_in_o, n1_o..n3_o                 registered letter and positions to the core
//   core_out_i                            combinational core result
//   out_valid_o/out_ready_i/out_letter_o  ciphertext handshake and registered letter
//   err_o                 sticky [0] non-one-hot key, [1] config value >25
//   n3_at_notch_o         rotor III sits on its turnover position
module enigma_controller
  import enigma_pkg::*;
#(
  parameter logic [4:0] NOTCH1_P = NOTCH1,
  parameter logic [4:0] NOTCH2_P = NOTCH2,
  parameter logic [4:0] NOTCH3_P = NOTCH3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cfg_load_i,
  input  logic [4:0]  cfg_n1_i,
  input  logic [4:0]  cfg_n2_i,
  input  logic [4:0]  cfg_n3_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [25:0] in_letter_i,
  output logic [25:0] core_in_o,
  output logic [4:0]  n1_o,
  output logic [4:0]  n2_o,
  output logic [4:0]  n3_o,
  input  logic [25:0] core_out_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [25:0] out_letter_o,
  output logic [1:0]  err_o,
  output logic        n3_at_notch_o
);

  state_t  state_q, state_d;
  letter_t core_in_q, core_in_d;
  letter_t out_letter_q, out_letter_d;
  pos_t    n1_q, n1_d, n2_q, n2_d, n3_q, n3_d;
  pos_t    step_n1, step_n2, step_n3;
  logic    out_valid_q, out_valid_d;
  logic [1:0] err_q, err_d;

  enigma_stepper #(
    .NOTCH1_P (NOTCH1_P),
    .NOTCH2_P (NOTCH2_P)
  ) u_stepper (
    .n1_i (n1_q),
    .n2_i (n2_q),
    .n3_i (n3_q),
    .n1_o (step_n1),
    .n2_o (step_n2),
    .n3_o (step_n3)
  );

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      core_in_q    <= 26'd0;
      out_letter_q <= 26'd0;
      out_valid_q  <= 1'b0;
      n1_q         <= 5'd0;
      n2_q         <= 5'd0;
      n3_q         <= 5'd0;
      err_q        <= 2'b00;
    end else begin
      state_q      <= state_d;
      core_in_q    <= core_in_d;
      out_letter_q <= out_letter_d;
      out_valid_q  <= out_valid_d;
      n1_q         <= n1_d;
      n2_q         <= n2_d;
      n3_q         <= n3_d;
      err_q        <= err_d;
    end
  end

  // Next state; a config load aborts any letter in flight.
  always_comb begin
    state_d = state_q;
    if (cfg_load_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (in_valid_i && is_onehot(in_letter_i)) state_d = ST_STEP;
                 else state_d = ST_IDLE;
        ST_STEP: state_d = ST_ENC;
        ST_ENC:  state_d = ST_HOLD;
        ST_HOLD: if (out_ready_i) state_d = ST_IDLE;
                 else state_d = ST_HOLD;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Next values of the registered outputs.
  always_comb begin
    core_in_d    = core_in_q;
    out_letter_d = out_letter_q;
    out_valid_d  = out_valid_q;
    n1_d         = n1_q;
    n2_d         = n2_q;
    n3_d         = n3_q;
    err_d        = err_q;
    if (cfg_load_i) begin
      n1_d        = pos_wrap(cfg_n1_i);
      n2_d        = pos_wrap(cfg_n2_i);
      n3_d        = pos_wrap(cfg_n3_i);
      err_d       = {pos_bad(cfg_n1_i) | pos_bad(cfg_n2_i) | pos_bad(cfg_n3_i), 1'b0};
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // A malformed key is dropped without touching the core input.
          if (in_valid_i) begin
            if (is_onehot(in_letter_i)) core_in_d = in_letter_i;
            else err_d[0] = 1'b1;
          end else begin
            core_in_d = core_in_q;
          end
        end
        ST_STEP: begin
          n1_d = step_n1;
          n2_d = step_n2;
          n3_d = step_n3;
        end
        ST_ENC: begin
          // Core sees the post-step positions by now.
          out_letter_d = core_out_i;
          out_valid_d  = 1'b1;
        end
        ST_HOLD: begin
          if (out_ready_i) out_valid_d = 1'b0;
          else out_valid_d = 1'b1;
        end
        default: out_valid_d = 1'b0;
      endcase
    end
  end

  assign in_ready_o    = (state_q == ST_IDLE) && !cfg_load_i;
  assign core_in_o     = core_in_q;
  assign n1_o          = n1_q;
  assign n2_o          = n2_q;
  assign n3_o          = n3_q;
  assign out_valid_o   = out_valid_q;
  assign out_letter_o  = out_letter_q;
  assign err_o         = err_q;
  assign n3_at_notch_o = (n3_q == NOTCH3_P);

endmodule

// File: tb/tb_enigma_controller.sv
// tb_enigma_controller: directed keypress/config sequences against a
// transaction-level rotor model, with a per-cycle compare process and
// a few hand-computed literal checks. A stand-in core scrambles letters
// by an arithmetic function of the letter and the three positions.
module tb_enigma_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_load;
  logic [4:0]  cfg_n1, cfg_n2, cfg_n3;
  logic        in_valid;
  logic        in_ready;
  logic [25:0] in_letter;
  logic [25:0] core_in;
  logic [4:0]  n1, n2, n3;
  logic [25:0] core_out;
  logic        out_valid;
  logic        out_ready;
  logic [25:0] out_letter;
  logic [1:0]  err;
  logic        n3_at_notch;

  int n_vec = 0;
  int n_miss = 0;
  bit chk_en = 1'b0;

  // Model state
  int          exp_n1, exp_n2, exp_n3;
  logic        exp_ov, exp_ir;
  logic [1:0]  exp_err;
  logic [25:0] exp_letter;

  always #5 clk = ~clk;

  enigma_controller dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .cfg_load_i    (cfg_load),
    .cfg_n1_i      (cfg_n1),
    .cfg_n2_i      (cfg_n2),
    .cfg_n3_i      (cfg_n3),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .in_letter_i   (in_letter),
    .core_in_o     (core_in),
    .n1_o          (n1),
    .n2_o          (n2),
    .n3_o          (n3),
    .core_out_i    (core_out),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_letter_o  (out_letter),
    .err_o         (err),
    .n3_at_notch_o (n3_at_notch)
  );

  function automatic logic [25:0] core_fn(int idx, int a, int b, int c);
    logic [25:0] one;
    one = 26'd1;
    if (idx < 0) return 26'd0;
    return one << ((idx + a + 2 * b + 5 * c + 3) % 26);
  endfunction

  // Stand-in enigma core driven by the DUT's registered outputs.
  always_comb begin
    int ci;
    ci = -1;
    for (int i = 0; i < 26; i++) if (core_in[i]) ci = i;
    core_out = core_fn(ci, int'(n1), int'(n2), int'(n3));
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, req);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("n1", 32'(n1), 32'(exp_n1));
      check("n2", 32'(n2), 32'(exp_n2));
      check("n3", 32'(n3), 32'(exp_n3));
      check("out_valid", 32'(out_valid), 32'(exp_ov));
      check("in_ready", 32'(in_ready), 32'(exp_ir));
      check("err", 32'(err), 32'(exp_err));
      check("n3_at_notch", 32'(n3_at_notch), 32'(exp_n3 == 21));
      if (exp_ov) check("out_letter", 32'(out_letter), 32'(exp_letter));
    end
  end

  // One keypress worth of rotor motion, following the machine's rules.
  task automatic model_step();
    bit c1, c2, s2, s3;
    c1 = (exp_n1 == 16);
    c2 = (exp_n2 == 4);
`ifdef ENIGMA_DOUBLE_STEP_EN
    s2 = c1 || c2;
    s3 = c2;
`else
    s2 = c1;
    s3 = c1 && c2;
`endif
    exp_n1 = (exp_n1 + 1) % 26;
    if (s2) exp_n2 = (exp_n2 + 1) % 26;
    if (s3) exp_n3 = (exp_n3 + 1) % 26;
  endtask

  task automatic model_reset();
    exp_n1 = 0; exp_n2 = 0; exp_n3 = 0;
    exp_ov = 1'b0; exp_ir = 1'b1; exp_err = 2'b00; exp_letter = 26'd0;
  endtask

  // Called at posedge+1; config takes effect on the next edge.
  task automatic cfg_apply(input int a, input int b, input int c);
    cfg_load = 1'b1;
    cfg_n1 = 5'(a); cfg_n2 = 5'(b); cfg_n3 = 5'(c);
    exp_ir = 1'b0;
    @(posedge clk); #1;
    cfg_load = 1'b0;
    exp_n1 = a % 26; exp_n2 = b % 26; exp_n3 = c % 26;
    exp_err = (a > 25 || b > 25 || c > 25) ? 2'b10 : 2'b00;
    exp_ov = 1'b0;
    exp_ir = 1'b1;
  endtask

  // ending: 0 = normal handshake, 1 = cfg abort during HOLD, 2 = reset during HOLD.
  task automatic press(input int idx, input int stall, input int ending);
    logic [25:0] one;
    one = 26'd1;
    in_valid = 1'b1;
    in_letter = one << idx;
    out_ready = (stall == 0 && ending == 0);
    @(posedge clk); #1;              // edge T: letter accepted
    in_valid = 1'b0; in_letter = 26'd0;
    exp_ir = 1'b0;
    @(posedge clk); #1;              // edge T+1: rotors step
    model_step();
    @(posedge clk); #1;              // edge T+2: result captured
    exp_ov = 1'b1;
    exp_letter = core_fn(idx, exp_n1, exp_n2, exp_n3);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
    end
    if (ending == 1) begin
      cfg_apply(30, 2, 1);
      out_ready = 1'b1;
    end else if (ending == 2) begin
      rst = 1'b1;
      model_reset();
      #1;
      check("rst_n1", 32'(n1), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      out_ready = 1'b1;
    end else begin
      out_ready = 1'b1;
      @(posedge clk); #1;            // handshake edge: back to IDLE
      exp_ov = 1'b0;
      exp_ir = 1'b1;
    end
  endtask

  initial begin
    logic [4:0] lit_n2, lit_n3;
    rst = 1'b1;
    cfg_load = 1'b0; cfg_n1 = 5'd0; cfg_n2 = 5'd0; cfg_n3 = 5'd0;
    in_valid = 1'b0; in_letter = 26'd0; out_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;
    @(posedge clk); #1;

    // First key from home position: n=(1,0,0), letter 0 -> (0+1+3)%26 = 4.
    press(0, 0, 0);
    check("t2_n1", 32'(n1), 32'd1);
    check("t2_n2n3", 32'({n2, n3}), 32'd0);
    check("t2_letter", 32'(out_letter), 32'h10);

    // Rotor I notch carries into rotor II.
    cfg_apply(16, 0, 0);
    press(5, 0, 0);
    check("t3a_pos", 32'({n1, n2, n3}), 32'({5'd17, 5'd1, 5'd0}));
    // Wrap of rotor I without any carry.
    cfg_apply(25, 25, 25);
    press(7, 0, 0);
    check("t3b_pos", 32'({n1, n2, n3}), 32'({5'd0, 5'd25, 5'd25}));

    // Rotor II arriving at its notch, then the double-step keypress.
    cfg_apply(16, 3, 0);
    press(1, 0, 0);
    check("t4a_pos", 32'({n1, n2, n3}), 32'({5'd17, 5'd4, 5'd0}));
    press(2, 0, 0);
`ifdef ENIGMA_DOUBLE_STEP_EN
    lit_n2 = 5'd5; lit_n3 = 5'd1;
`else
    lit_n2 = 5'd4; lit_n3 = 5'd0;
`endif
    check("t4b_pos", 32'({n1, n2, n3}), 32'({5'd18, lit_n2, lit_n3}));

    // Backpressure for 5 cycles; rotor III moving onto its notch in double-step builds.
    cfg_apply(3, 4, 20);
    press(9, 5, 0);
    cfg_apply(0, 0, 21);
    @(posedge clk); #1;
    check("notch3", 32'(n3_at_notch), 32'd1);

    // Malformed key: flagged, dropped, nothing moves.
    in_valid = 1'b1; in_letter = 26'h3;
    @(posedge clk); #1;
    in_valid = 1'b0; in_letter = 26'd0;
    exp_err = exp_err | 2'b01;
    repeat (3) @(posedge clk);
    #1;
    check("t6_err0", 32'(err), 32'b01);

    // Config during HOLD: n1=30 folds to 4, err becomes 2'b10, output withdrawn.
    press(11, 3, 1);
    check("t6_n1", 32'(n1), 32'd4);
    check("t6_err", 32'(err), 32'b10);
    check("t6_ov", 32'(out_valid), 32'd0);
    @(posedge clk); #1;

    // Reset while holding a result, then normal operation resumes from home.
    cfg_apply(7, 8, 9);
    press(12, 2, 2);
    @(posedge clk); #1;
    press(0, 0, 0);
    check("t1_letter", 32'(out_letter), 32'h10);
    press(25, 1, 0);

    repeat (2) @(posedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
